// File: rtl/iob_ram_t2p_be_clr.sv
// Single-clock two-port RAM with byte strobes, 1- or 2-cycle read latency, optional write-to-read
// forwarding and a sequencer that fills every word with CLR_VAL after reset or on request.
module iob_ram_t2p_be_clr #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 10,
    parameter int                READ_LAT = 1,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = {DATA_W{1'b0}}
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    input  logic                   w_en_i,
    input  logic [DATA_W/8-1:0]    w_strb_i,
    input  logic [ADDR_W-1:0]      w_addr_i,
    input  logic [DATA_W-1:0]      w_data_i,
    input  logic                   r_en_i,
    input  logic [ADDR_W-1:0]      r_addr_i,
    output logic [DATA_W-1:0]      r_data_o,
    output logic                   r_valid_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] ptr_r;

    logic              idle_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;
    logic [STRB_W-1:0] mem_strb_s;
    logic              rd_issue_s;
    logic              bypass_hit_s;

    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // Write-port mux: the clear sequencer owns the write port while it runs.
    always_comb begin
        idle_s       = (state_r == ST_IDLE);
        mem_we_s     = 1'b0;
        mem_addr_s   = w_addr_i;
        mem_data_s   = w_data_i;
        mem_strb_s   = w_strb_i;
        rd_issue_s   = 1'b0;
        bypass_hit_s = 1'b0;
        if (idle_s) begin
            mem_we_s     = w_en_i;
            rd_issue_s   = r_en_i;
            bypass_hit_s = (BYPASS != 0) && w_en_i && (w_addr_i == r_addr_i);
        end else begin
            mem_we_s   = 1'b1;
            mem_addr_s = ptr_r;
            mem_data_s = CLR_VAL;
            mem_strb_s = {STRB_W{1'b1}};
        end
    end

    // Clear sequencer: one word per cycle, leaves on the edge that writes the last address.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (ptr_r == {ADDR_W{1'b1}}) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= {ADDR_W{1'b0}};
                    end else begin
                        ptr_r <= ptr_r + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ptr_r   <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign busy_o = (state_r == ST_CLEAR);

    // Byte-strobed memory write; no writes while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we_s) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (mem_strb_s[k]) begin
                    mem[mem_addr_s][8*k +: 8] <= mem_data_s[8*k +: 8];
                end
            end
        end
    end

    // First read stage; data holds when no read is issued.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_issue_s;
            if (rd_issue_s) begin
                rd_data_r <= bypass_hit_s ? merge_bytes(mem[r_addr_i], w_data_i, w_strb_i)
                                          : mem[r_addr_i];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] out_data_r;
            logic              out_valid_r;

            // Extra output register for the two-cycle latency build.
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    out_data_r  <= {DATA_W{1'b0}};
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= rd_valid_r;
                    if (rd_valid_r) begin
                        out_data_r <= rd_data_r;
                    end
                end
            end

            assign r_data_o  = out_data_r;
            assign r_valid_o = out_valid_r;
        end else begin : g_lat1
            assign r_data_o  = rd_data_r;
            assign r_valid_o = rd_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_iob_ram_t2p_be_clr.sv
// Drives a READ_LAT=1/BYPASS=1 and a READ_LAT=2/BYPASS=0 instance with identical stimulus and
// compares both against a word-array reference model every cycle.
module tb_iob_ram_t2p_be_clr;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int STRB_W = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clr, w_en, r_en;
    logic [STRB_W-1:0] w_strb;
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [DATA_W-1:0] w_data;
    logic              busy1, busy2, v1, v2;
    logic [DATA_W-1:0] d1, d2;

    iob_ram_t2p_be_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(1), .BYPASS(1),
                         .CLR_VAL(32'h0000_0000)) u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy1),
        .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
        .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(d1), .r_valid_o(v1)
    );

    iob_ram_t2p_be_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(2), .BYPASS(0),
                         .CLR_VAL(32'h0000_0000)) u_lat2 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .busy_o(busy2),
        .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr), .w_data_i(w_data),
        .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(d2), .r_valid_o(v2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: memory contents, remaining clear cycles, expected outputs per instance.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_clr_left = 0;
    logic [DATA_W-1:0] e_d1 = '0, e_d2 = '0, p_d2 = '0;
    logic              e_v1 = 1'b0, e_v2 = 1'b0, p_v2 = 1'b0;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                                input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = o;
        for (int k = 0; k < STRB_W; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_fill_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0000_0000;
        m_clr_left = DEPTH;
    endtask

    task automatic model_edge();
        logic [DATA_W-1:0] old;
        if (!rst_n) begin
            model_fill_clear();
            e_d1 = '0; e_v1 = 1'b0; e_d2 = '0; e_v2 = 1'b0; p_v2 = 1'b0;
        end else begin
            e_v2 = p_v2;
            if (p_v2) e_d2 = p_d2;
            if (m_clr_left > 0) begin
                m_clr_left--;
                e_v1 = 1'b0;
                p_v2 = 1'b0;
            end else begin
                old  = m_mem[r_addr];
                e_v1 = r_en;
                p_v2 = r_en;
                if (r_en) begin
                    e_d1 = (w_en && w_addr == r_addr) ? merge(old, w_data, w_strb) : old;
                    p_d2 = old;
                end
                if (w_en) m_mem[w_addr] = merge(m_mem[w_addr], w_data, w_strb);
                if (clr) model_fill_clear();
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic cycle(input logic rs, input logic c, input logic we, input logic [STRB_W-1:0] s,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic re, input logic [ADDR_W-1:0] ra);
        rst_n = rs; clr = c; w_en = we; w_strb = s; w_addr = wa; w_data = wd; r_en = re; r_addr = ra;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("busy1",  {31'b0, busy1}, {31'b0, m_clr_left > 0});
        check_eq("busy2",  {31'b0, busy2}, {31'b0, m_clr_left > 0});
        check_eq("valid1", {31'b0, v1}, {31'b0, e_v1});
        check_eq("data1",  d1, e_d1);
        check_eq("valid2", {31'b0, v2}, {31'b0, e_v2});
        check_eq("data2",  d2, e_d2);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b0, 7'd0);
    endtask
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        cycle(1'b1, 1'b0, 1'b1, s, a, d, 1'b0, 7'd0);
    endtask
    task automatic rd(input logic [ADDR_W-1:0] a);
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 7'd0, 32'h0, 1'b1, a);
    endtask
    task automatic noisy(input logic rs);
        cycle(rs, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 7'($urandom), $urandom,
              1'($urandom_range(0, 1)), 7'($urandom));
    endtask

    // Busy must be seen on the cycle right after release plus the following DEPTH-1 cycles.
    task automatic measure_busy(input string tag);
        int cnt;
        cnt = int'(busy1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            noisy(1'b1);
            cnt += int'(busy1);
        end
        check_eq(tag, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
        w_strb = '0; w_addr = '0; w_data = '0; r_addr = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) noisy(1'b0);
        check_eq("rst_data1", d1, 32'h0000_0000);
        check_eq("rst_data2", d2, 32'h0000_0000);
        measure_busy("busy_len_reset");
        for (int i = 0; i < DEPTH; i++) rd(7'(i));
        idle();

        for (int i = 0; i < DEPTH; i++) wr(7'(i), 32'(i + 32), 4'hF);
        for (int i = 0; i < DEPTH; i++) begin
            rd(7'(i));
            check_eq("seq_lat1", d1, 32'(i + 32));
            if (i > 0) check_eq("seq_lat2", d2, 32'(i + 31));
        end
        idle();
        check_eq("seq_lat2_last", d2, 32'(DEPTH + 31));

        wr(7'd5, 32'hAABB_CCDD, 4'hF);
        wr(7'd5, 32'h1122_3344, 4'b0101);
        wr(7'd5, 32'hFFFF_FFFF, 4'b0000);
        rd(7'd5);
        check_eq("strb_lat1", d1, 32'hAA22_CC44);
        idle();
        check_eq("strb_lat2", d2, 32'hAA22_CC44);

        cycle(1'b1, 1'b0, 1'b1, 4'hF, 7'd7, 32'hDEAD_BEEF, 1'b1, 7'd7);
        check_eq("bypass1", d1, 32'hDEAD_BEEF);
        rd(7'd7);
        check_eq("bypass0_old", d2, 32'h0000_0027);
        idle();
        check_eq("bypass0_new", d2, 32'hDEAD_BEEF);

        rd(7'd32);
        idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            check_eq("hold_v1", {31'b0, v1}, 32'h0);
            check_eq("hold_d1", d1, 32'h0000_0040);
            check_eq("hold_d2", d2, 32'h0000_0040);
        end

        cycle(1'b1, 1'b1, 1'b1, 4'hF, 7'd9, 32'h1234_5678, 1'b1, 7'd9);
        for (int i = 0; i < 100; i++) noisy(1'b1);
        noisy(1'b0);
        measure_busy("busy_len_restart");
        for (int i = 0; i < DEPTH; i++) rd(7'(i));

        for (int i = 0; i < 3000; i++) begin
            cycle(1'b1, ($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
                  7'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
